// File: rtl/usb_fs_out_ep_rx.sv
// ============================================================================
// Module      : usb_fs_out_ep_rx
// Description : USB full-speed OUT endpoint receive path. Watches decoded
//               packet events for an OUT/SETUP token matching dev_addr/ep_num,
//               buffers the following DATA0/DATA1 payload speculatively into a
//               byte FIFO, commits it (CRC16 bytes stripped) only when the
//               packet is good, requests an ACK/NAK handshake and tracks the
//               data toggle.
// Options     : `define USB_OUT_EP_STALL_EN adds input ep_stall; while it is
//               high a good OUT data packet is discarded and answered with
//               STALL. SETUP is never stalled.
// Ports       : clk, reset_n            - clock, async active-low reset
//               dev_addr, ep_num        - address / endpoint to match
//               rx_pkt_start/_end       - packet boundary pulses
//               rx_pid/addr/endp        - decoded fields, valid at rx_pkt_end
//               rx_data_put, rx_data    - received byte strobe and value
//               rx_valid_packet         - PID+CRC good for latest packet
//               rd_en, rd_data          - FIFO pop request / popped byte
//               empty, level            - committed byte status
//               hs_req, hs_pid          - handshake request pulse and PID
//               setup_rcvd              - pulse when a SETUP payload commits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_fs_out_ep_rx #(
    parameter int DEPTH   = 64,
    parameter int MAX_PKT = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [6:0]               dev_addr,
    input  logic [3:0]               ep_num,
`ifdef USB_OUT_EP_STALL_EN
    input  logic                     ep_stall,
`endif
    input  logic                     rx_pkt_start,
    input  logic                     rx_pkt_end,
    input  logic [3:0]               rx_pid,
    input  logic [6:0]               rx_addr,
    input  logic [3:0]               rx_endp,
    input  logic                     rx_data_put,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid_packet,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     hs_req,
    output logic [3:0]               hs_pid,
    output logic                     setup_rcvd
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(MAX_PKT + 3);

    localparam logic [PW-1:0] c_DEPTH      = PW'(DEPTH);
    localparam logic [TW-1:0] c_TIMEOUT_M1 = TW'(TIMEOUT - 1);
    // Payload plus both CRC bytes is the longest legal packet.
    localparam logic [BW-1:0] c_BYTE_LIMIT = BW'(MAX_PKT + 2);

    localparam logic [3:0] c_PID_OUT   = 4'b0001;
    localparam logic [3:0] c_PID_SETUP = 4'b1101;
    localparam logic [3:0] c_PID_DATA0 = 4'b0011;
    localparam logic [3:0] c_PID_DATA1 = 4'b1011;
    localparam logic [3:0] c_PID_ACK   = 4'b0010;
    localparam logic [3:0] c_PID_NAK   = 4'b1010;
`ifdef USB_OUT_EP_STALL_EN
    localparam logic [3:0] c_PID_STALL = 4'b1110;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TOKEN = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          chk_data_q, chk_data_d;     // CHECK is judging a data packet
    logic          setup_cand_q, setup_cand_d; // pending token was SETUP
    logic          is_setup_q, is_setup_d;
    logic          toggle_q, toggle_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] bytecnt_q, bytecnt_d;
    logic          ovf_q, ovf_d;
    logic          babble_q, babble_d;
    logic [3:0]    pid_q, pid_d;
    logic [PW-1:0] wr_tmp_q, wr_tmp_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          hs_req_q, hs_req_d;
    logic [3:0]    hs_pid_q, hs_pid_d;
    logic          setup_rcvd_q, setup_rcvd_d;

    logic [7:0]    mem [DEPTH];
    logic          w_wr_en;
    logic          w_tok_match;
    logic          w_bad;
    logic          w_stall;
    logic [PW-1:0] w_level;

    assign w_level = wr_ptr_q - rd_ptr_q;
    assign level   = w_level;
    assign empty   = (w_level == '0);
    assign rd_data    = rd_data_q;
    assign hs_req     = hs_req_q;
    assign hs_pid     = hs_pid_q;
    assign setup_rcvd = setup_rcvd_q;

    assign w_tok_match = rx_pkt_end
                       && (rx_pid == c_PID_OUT || rx_pid == c_PID_SETUP)
                       && (rx_addr == dev_addr) && (rx_endp == ep_num);

    // Reasons a data packet is dropped silently.
    assign w_bad = !(pid_q == c_PID_DATA0 || pid_q == c_PID_DATA1)
                 || !rx_valid_packet || babble_q || (bytecnt_q < BW'(2));

`ifdef USB_OUT_EP_STALL_EN
    assign w_stall = ep_stall && !is_setup_q;
`else
    assign w_stall = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_tok_match) state_d = S_CHECK;
            S_TOKEN: begin
                if (rx_pkt_start)
                    state_d = S_DATA;
                else if (rx_pkt_end || timer_q == c_TIMEOUT_M1)
                    state_d = S_IDLE;
            end
            S_DATA:  if (rx_pkt_end) state_d = S_CHECK;
            S_CHECK: state_d = (!chk_data_q && rx_valid_packet) ? S_TOKEN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------- outputs/datapath
    always_comb begin
        chk_data_d   = chk_data_q;
        setup_cand_d = setup_cand_q;
        is_setup_d   = is_setup_q;
        toggle_d     = toggle_q;
        timer_d      = timer_q;
        bytecnt_d    = bytecnt_q;
        ovf_d        = ovf_q;
        babble_d     = babble_q;
        pid_d        = pid_q;
        wr_tmp_d     = wr_tmp_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_data_d    = rd_data_q;
        hs_req_d     = 1'b0;
        hs_pid_d     = hs_pid_q;
        setup_rcvd_d = 1'b0;
        w_wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_tok_match) begin
                    chk_data_d   = 1'b0;
                    setup_cand_d = (rx_pid == c_PID_SETUP);
                end
            end
            S_TOKEN: begin
                timer_d = timer_q + TW'(1);
                if (rx_pkt_start) begin
                    wr_tmp_d  = wr_ptr_q;
                    bytecnt_d = '0;
                    ovf_d     = 1'b0;
                    babble_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (rx_data_put) begin
                    if (babble_q || bytecnt_q == c_BYTE_LIMIT) begin
                        babble_d = 1'b1;
                    end else if (wr_tmp_q - rd_ptr_q == c_DEPTH) begin
                        // Keep counting so short/long detection still works.
                        ovf_d     = 1'b1;
                        bytecnt_d = bytecnt_q + BW'(1);
                    end else begin
                        w_wr_en   = 1'b1;
                        wr_tmp_d  = wr_tmp_q + PW'(1);
                        bytecnt_d = bytecnt_q + BW'(1);
                    end
                end
                if (rx_pkt_end) begin
                    pid_d      = rx_pid;
                    chk_data_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (!chk_data_q) begin
                    if (rx_valid_packet) begin
                        is_setup_d = setup_cand_q;
                        timer_d    = '0;
                        if (setup_cand_q) toggle_d = 1'b0;
                    end
                end else if (w_bad) begin
                    // dropped, no handshake
                end else if (w_stall) begin
`ifdef USB_OUT_EP_STALL_EN
                    hs_req_d = 1'b1;
                    hs_pid_d = c_PID_STALL;
`endif
                end else if (ovf_q) begin
                    if (!is_setup_q) begin
                        hs_req_d = 1'b1;
                        hs_pid_d = c_PID_NAK;
                    end
                end else if (pid_q[3] != toggle_q) begin
                    // Host retry of an already accepted packet.
                    hs_req_d = 1'b1;
                    hs_pid_d = c_PID_ACK;
                end else begin
                    wr_ptr_d     = wr_tmp_q - PW'(2);
                    toggle_d     = ~toggle_q;
                    hs_req_d     = 1'b1;
                    hs_pid_d     = c_PID_ACK;
                    setup_rcvd_d = is_setup_q;
                end
            end
            default: ;
        endcase

        // Read port runs independently of the receive state machine.
        if (rd_en && !empty) begin
            rd_data_d = mem[rd_ptr_q[AW-1:0]];
            rd_ptr_d  = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) mem[wr_tmp_q[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_data_q   <= 1'b0;
            setup_cand_q <= 1'b0;
            is_setup_q   <= 1'b0;
            toggle_q     <= 1'b0;
            timer_q      <= '0;
            bytecnt_q    <= '0;
            ovf_q        <= 1'b0;
            babble_q     <= 1'b0;
            pid_q        <= '0;
            wr_tmp_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            hs_req_q     <= 1'b0;
            hs_pid_q     <= '0;
            setup_rcvd_q <= 1'b0;
        end else begin
            chk_data_q   <= chk_data_d;
            setup_cand_q <= setup_cand_d;
            is_setup_q   <= is_setup_d;
            toggle_q     <= toggle_d;
            timer_q      <= timer_d;
            bytecnt_q    <= bytecnt_d;
            ovf_q        <= ovf_d;
            babble_q     <= babble_d;
            pid_q        <= pid_d;
            wr_tmp_q     <= wr_tmp_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_data_q    <= rd_data_d;
            hs_req_q     <= hs_req_d;
            hs_pid_q     <= hs_pid_d;
            setup_rcvd_q <= setup_rcvd_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_fs_out_ep_rx.sv
// ============================================================================
// Module      : tb_usb_fs_out_ep_rx
// Description : Self-checking bench for usb_fs_out_ep_rx. Expected handshakes
//               and committed bytes are queued as packets are driven and
//               popped when the DUT raises hs_req or returns rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_usb_fs_out_ep_rx;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] dev_addr = 7'd5;
    logic [3:0] ep_num = 4'd1;
    logic       ep_stall = 1'b0;
    logic       rx_pkt_start = 1'b0;
    logic       rx_pkt_end = 1'b0;
    logic [3:0] rx_pid = '0;
    logic [6:0] rx_addr = '0;
    logic [3:0] rx_endp = '0;
    logic       rx_data_put = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid_packet = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic [6:0] level;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       setup_rcvd;

    usb_fs_out_ep_rx #(.DEPTH(64), .MAX_PKT(64), .TIMEOUT(255)) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .dev_addr        (dev_addr),
        .ep_num          (ep_num),
`ifdef USB_OUT_EP_STALL_EN
        .ep_stall        (ep_stall),
`endif
        .rx_pkt_start    (rx_pkt_start),
        .rx_pkt_end      (rx_pkt_end),
        .rx_pid          (rx_pid),
        .rx_addr         (rx_addr),
        .rx_endp         (rx_endp),
        .rx_data_put     (rx_data_put),
        .rx_data         (rx_data),
        .rx_valid_packet (rx_valid_packet),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .empty           (empty),
        .level           (level),
        .hs_req          (hs_req),
        .hs_pid          (hs_pid),
        .setup_rcvd      (setup_rcvd)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         setup_cnt = 0;
    int         exp_setups = 0;
    logic [3:0] hs_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] pay[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake / setup monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && hs_req) begin
                if (hs_q.size() == 0) check("hs_unexpected", 32'(hs_req), 32'd0);
                else                  check("hs_pid", 32'(hs_pid), 32'(hs_q.pop_front()));
            end
            if (reset_n && setup_rcvd) setup_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mk_pay(input int n, input int seed);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(seed + i * 7));
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp);
        tick(); rx_pkt_start = 1'b1;
        tick(); rx_pkt_start = 1'b0;
        tick();
        rx_pkt_end = 1'b1; rx_pid = pid; rx_addr = addr; rx_endp = endp;
        rx_valid_packet = 1'b1;
        tick(); rx_pkt_end = 1'b0;
        tick(); tick();
    endtask

    // Sends pay[] plus two CRC bytes; queues expectations before driving.
    task automatic send_data(input logic [3:0] pid, input logic valid,
                             input logic exp_hs, input logic [3:0] exp_pid,
                             input logic commit);
        if (exp_hs) hs_q.push_back(exp_pid);
        if (commit) foreach (pay[i]) rd_q.push_back(pay[i]);
        tick(); rx_pkt_start = 1'b1; rx_valid_packet = 1'b0;
        tick(); rx_pkt_start = 1'b0;
        for (int i = 0; i < pay.size() + 2; i++) begin
            rx_data_put = 1'b1;
            rx_data = (i < pay.size()) ? pay[i] : 8'(8'hC0 + i);
            tick(); rx_data_put = 1'b0;
            tick();
        end
        rx_pkt_end = 1'b1; rx_pid = pid; rx_valid_packet = valid;
        tick(); rx_pkt_end = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic chk_state(input string tag);
        @(negedge clk);
        check({tag, "_level"}, 32'(level), 32'(rd_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(rd_q.size() == 0));
        check({tag, "_hs_pending"}, 32'(hs_q.size()), 32'd0);
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); rd_en = 1'b1;
            tick(); rd_en = 1'b0;
            @(negedge clk);
            if (rd_q.size() == 0) check("rd_underflow", 32'(rd_q.size()), 32'd1);
            else                  check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
    endtask

    initial begin
        // Reset values
        #12;
        @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_hs_req", 32'(hs_req), 32'd0);
        check("rst_hs_pid", 32'(hs_pid), 32'd0);
        check("rst_setup", 32'(setup_rcvd), 32'd0);
        tick(); reset_n = 1'b1;
        tick();

        // Basic OUT DATA0 accepted
        mk_pay(4, 0);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1);
        chk_state("out0");

        // Duplicate DATA0 retry: ACK, not stored
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b0);
        chk_state("dup");
        pop(4);
        chk_state("drain4");

        // Bad CRC on DATA1: silent discard
        mk_pay(4, 8'h50);
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA1, 1'b0, 1'b0, PID_ACK, 1'b0);
        chk_state("badcrc");

        // Fill to 60, then overflow NAK, free space, retry
        mk_pay(60, 8'h01);
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA1, 1'b1, 1'b1, PID_ACK, 1'b1);
        chk_state("fill60");
        mk_pay(8, 8'hA0);
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA0, 1'b1, 1'b1, PID_NAK, 1'b0);
        chk_state("nak");
        pop(10);
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1);
        chk_state("retry58");
        pop(58);
        chk_state("drain58");

        // SETUP after a DATA0 commit (toggle was 1): forced back to DATA0
        mk_pay(8, 8'h80);
        exp_setups++;
        send_token(PID_SETUP, 7'd5, 4'd1);
        send_data(PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1);
        chk_state("setup");
        check("setup_pulses", 32'(setup_cnt), 32'(exp_setups));

        // Token for another endpoint: ignored
        mk_pay(4, 8'h30);
        send_token(PID_OUT, 7'd5, 4'd2);
        send_data(PID_DATA1, 1'b1, 1'b0, PID_ACK, 1'b0);
        chk_state("ep2");

        // Token timeout, then data with no token
        send_token(PID_OUT, 7'd5, 4'd1);
        repeat (300) tick();
        send_data(PID_DATA1, 1'b1, 1'b0, PID_ACK, 1'b0);
        chk_state("timeout");

        // Babble: MAX_PKT+1 payload bytes
        mk_pay(65, 8'h10);
        send_token(PID_OUT, 7'd5, 4'd1);
        send_data(PID_DATA1, 1'b1, 1'b0, PID_ACK, 1'b0);
        chk_state("babble");

        // Too short (one byte, less than CRC)
        pay.delete();
        send_token(PID_OUT, 7'd5, 4'd1);
        tick(); rx_pkt_start = 1'b1;
        tick(); rx_pkt_start = 1'b0;
        rx_data_put = 1'b1; rx_data = 8'h99;
        tick(); rx_data_put = 1'b0;
        rx_pkt_end = 1'b1; rx_pid = PID_DATA1; rx_valid_packet = 1'b1;
        tick(); rx_pkt_end = 1'b0;
        tick(); tick(); tick();
        chk_state("short");

        // Reset in the middle of a data packet
        send_token(PID_OUT, 7'd5, 4'd1);
        tick(); rx_pkt_start = 1'b1;
        tick(); rx_pkt_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_data_put = 1'b1; rx_data = 8'(i);
            tick(); rx_data_put = 1'b0;
        end
        reset_n = 1'b0;
        rd_q.delete();
        @(negedge clk);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_hs_pid", 32'(hs_pid), 32'd0);
        tick(); reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data_put = 1'b1; rx_data = 8'(i + 3);
            tick(); rx_data_put = 1'b0;
        end
        rx_pkt_end = 1'b1; rx_pid = PID_DATA1; rx_valid_packet = 1'b1;
        tick(); rx_pkt_end = 1'b0;
        tick(); tick(); tick();
        chk_state("postrst");

        // Read request while empty leaves rd_data unchanged
        tick(); rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        @(negedge clk);
        check("rd_empty_hold", 32'(rd_data), 32'd0);
        check("setup_total", 32'(setup_cnt), 32'(exp_setups));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
